vga_scan_gen: RTL

Raster scan generator and video output stage for the DE0-Nano VGA path. Drives the pixel coordinate bus (`PIXEL_H`, `PIXEL_V`) into the pixel renderers, such as the text renderer, and takes back their 3-bit `PIXEL` colour. It delays sync and blanking to match the renderer's latency, then drives registered RGB and sync pins for an 800x600@72 Hz display from the 50 MHz board clock.

---
 rtl/vga_scan_gen.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/vga_scan_gen.sv
// vga_scan_gen: raster scan counters, sync/blank decode, renderer-latency
// alignment pipeline and registered VGA output pins (800x600@72 default).
//
// Ports:
//   clk, rst_n          pixel clock, asynchronous active-low reset
//   PIXEL_H, PIXEL_V    coordinate bus issued to the pixel renderers
//   PIXEL               {R,G,B} returned PIX_LAT clocks after coordinate
//   VGA_R/G/B           registered colour pins, zero during blanking
//   VGA_HS, VGA_VS      registered sync pins, polarity set by SYNC_POS
//   frame_start         high while the coordinate bus shows (0,0)

module vga_scan_gen #(
    parameter int H_VISIBLE = 800,
    parameter int H_FRONT   = 56,
    parameter int H_SYNC    = 120,
    parameter int H_BACK    = 64,
    parameter int V_VISIBLE = 600,
    parameter int V_FRONT   = 37,
    parameter int V_SYNC    = 6,
    parameter int V_BACK    = 23,
    parameter int SYNC_POS  = 1,
    parameter int PIX_LAT   = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [10:0] PIXEL_H,
    output logic [10:0] PIXEL_V,
    input  logic [2:0]  PIXEL,
    output logic        VGA_R,
    output logic        VGA_G,
    output logic        VGA_B,
    output logic        VGA_HS,
    output logic        VGA_VS,
    output logic        frame_start
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
    localparam logic [10:0] H_ACT    = 11'(H_VISIBLE);
    localparam logic [10:0] V_ACT    = 11'(V_VISIBLE);
    localparam logic [10:0] HS_FIRST = 11'(H_VISIBLE + H_FRONT);
    localparam logic [10:0] HS_LAST  = 11'(H_VISIBLE + H_FRONT + H_SYNC - 1);
    localparam logic [10:0] VS_FIRST = 11'(V_VISIBLE + V_FRONT);
    localparam logic [10:0] VS_LAST  = 11'(V_VISIBLE + V_FRONT + V_SYNC - 1);

    // Inverting the internal active-high sync gives active-low pins.
    localparam logic SYNC_INV = (SYNC_POS == 0);

    // ------------------------------------------------------------------
    // Scan counters
    // ------------------------------------------------------------------
    logic [10:0] h_q, h_d;
    logic [10:0] v_q, v_d;

    always_comb begin
        h_d = h_q + 11'd1;
        v_d = v_q;
        if (h_q == H_LAST) begin
            h_d = '0;
            if (v_q == V_LAST) begin
                v_d = '0;
            end else begin
                v_d = v_q + 11'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_q <= '0;
            v_q <= '0;
        end else begin
            h_q <= h_d;
            v_q <= v_d;
        end
    end

    assign PIXEL_H     = h_q;
    assign PIXEL_V     = v_q;
    assign frame_start = (h_q == '0) && (v_q == '0);

    // ------------------------------------------------------------------
    // Stage-0 decode: {active, hs, vs}, all active-high
    // ------------------------------------------------------------------
    logic       active_s0;
    logic       hs_s0;
    logic       vs_s0;
    logic [2:0] dec_s0;
    logic [2:0] dec_al;

    assign active_s0 = (h_q < H_ACT) && (v_q < V_ACT);
    assign hs_s0     = (h_q >= HS_FIRST) && (h_q <= HS_LAST);
    assign vs_s0     = (v_q >= VS_FIRST) && (v_q <= VS_LAST);
    assign dec_s0    = {active_s0, hs_s0, vs_s0};

    // ------------------------------------------------------------------
    // Alignment: delay the decode by the renderer latency so it lines
    // up with the PIXEL value for the same coordinate.
    // ------------------------------------------------------------------
    generate
        if (PIX_LAT == 0) begin : g_nolat
            assign dec_al = dec_s0;
        end else begin : g_lat
            logic [2:0] shift_q [PIX_LAT];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < PIX_LAT; i++) begin
                        shift_q[i] <= '0;
                    end
                end else begin
                    shift_q[0] <= dec_s0;
                    for (int i = 1; i < PIX_LAT; i++) begin
                        shift_q[i] <= shift_q[i-1];
                    end
                end
            end

            assign dec_al = shift_q[PIX_LAT-1];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Output register
    // ------------------------------------------------------------------
    logic [2:0] rgb_q, rgb_d;
    logic       hs_q, hs_d;
    logic       vs_q, vs_d;

    always_comb begin
        rgb_d = '0;
        if (dec_al[2]) begin
            rgb_d = PIXEL;
        end
        hs_d = dec_al[1] ^ SYNC_INV;
        vs_d = dec_al[0] ^ SYNC_INV;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rgb_q <= '0;
            hs_q  <= SYNC_INV;
            vs_q  <= SYNC_INV;
        end else begin
            rgb_q <= rgb_d;
            hs_q  <= hs_d;
            vs_q  <= vs_d;
        end
    end

    assign VGA_R  = rgb_q[2];
    assign VGA_G  = rgb_q[1];
    assign VGA_B  = rgb_q[0];
    assign VGA_HS = hs_q;
    assign VGA_VS = vs_q;

endmodule
